// File: rtl/aib_cfg_avmm_pkg.sv
// Shared types and constants for the AIB configuration Avalon-MM responder.
package aib_cfg_avmm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RDV  = 2'd2,
        RDV2 = 2'd3
    } cfg_state_e;

    localparam int unsigned VERSION  = 0;
    localparam int unsigned STATUS   = 7;
    localparam int unsigned NUM_REGS = 8;

    localparam logic [31:0] VERSION_VALUE = 32'h0A1B_0100;

    localparam int unsigned ST_RW_BOTH = 0;
    localparam int unsigned ST_OOR     = 1;

    function automatic logic [31:0] version_word(input logic [5:0] channel_id);
        return VERSION_VALUE | {26'd0, channel_id};
    endfunction

endpackage

// File: rtl/aib_cfg_avmm_regfile.sv
// Register storage: version word, six byte-maskable R/W words and a W1C status word.
module aib_cfg_avmm_regfile
    import aib_cfg_avmm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   channel_id,
    input  logic         wr_en,
    input  logic [2:0]   wr_off,
    input  logic [3:0]   byte_en,
    input  logic [31:0]  wdata,
    input  logic         set_rw_both,
    input  logic         set_oor,
    input  logic [2:0]   rd_off,
    output logic [31:0]  rd_data,
    output logic [191:0] csr_reg
);

    logic [31:0] regs [1:6];
    logic [1:0]  status;
    logic [1:0]  status_nxt;

    always_comb begin
        status_nxt = status;
        if (wr_en && wr_off == 3'(STATUS) && byte_en[0])
            status_nxt = status & ~wdata[1:0];
        // a flag raised in the same cycle as its clear stays set
        if (set_rw_both)
            status_nxt[ST_RW_BOTH] = 1'b1;
        if (set_oor)
            status_nxt[ST_OOR] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 1; r < STATUS; r++)
                regs[r] <= '0;
            status <= '0;
        end else begin
            status <= status_nxt;
            for (int unsigned r = 1; r < STATUS; r++) begin
                if (wr_en && wr_off == 3'(r)) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (byte_en[b])
                            regs[r][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_off == 3'(VERSION))
            rd_data = version_word(channel_id);
        else if (rd_off == 3'(STATUS))
            rd_data = {30'd0, status};
        else begin
            for (int unsigned r = 1; r < STATUS; r++) begin
                if (rd_off == 3'(r))
                    rd_data = regs[r];
            end
        end
    end

    assign csr_reg = {regs[6], regs[5], regs[4], regs[3], regs[2], regs[1]};

endmodule

// File: rtl/aib_cfg_avmm_rsp.sv
// Per-channel Avalon-MM config responder: address decode and handshake FSM.
// Define AIB_CFG_AVMM_RDPIPE_EN to add one register stage on the read-data path.
module aib_cfg_avmm_rsp
    import aib_cfg_avmm_pkg::*;
(
    input  logic         i_cfg_avmm_clk,
    input  logic         i_cfg_avmm_rst,
    input  logic [5:0]   i_channel_id,
    input  logic [16:0]  i_cfg_avmm_addr,
    input  logic [3:0]   i_cfg_avmm_byte_en,
    input  logic         i_cfg_avmm_read,
    input  logic         i_cfg_avmm_write,
    input  logic [31:0]  i_cfg_avmm_wdata,
    output logic [31:0]  o_cfg_avmm_rdata,
    output logic         o_cfg_avmm_rdatavld,
    output logic         o_cfg_avmm_waitreq,
    output logic [191:0] o_csr_reg
);

    cfg_state_e  state;
    logic [8:0]  word_off;
    logic        hit;
    logic        in_range;
    logic        in_ack;
    logic [31:0] rf_rdata;
    logic        unused_addr_lsb;
`ifdef AIB_CFG_AVMM_RDPIPE_EN
    logic [31:0] rd_pipe;
`endif

    assign word_off        = i_cfg_avmm_addr[10:2];
    assign hit             = (i_cfg_avmm_read || i_cfg_avmm_write) &&
                             (i_cfg_avmm_addr[16:11] == i_channel_id);
    assign in_range        = word_off < 9'(NUM_REGS);
    assign in_ack          = (state == ACK);
    assign unused_addr_lsb = ^i_cfg_avmm_addr[1:0];

    // The master holds the request stable through ACK, so the commit uses live inputs.
    aib_cfg_avmm_regfile u_regfile (
        .clk         (i_cfg_avmm_clk),
        .rst         (i_cfg_avmm_rst),
        .channel_id  (i_channel_id),
        .wr_en       (in_ack && i_cfg_avmm_write && in_range),
        .wr_off      (word_off[2:0]),
        .byte_en     (i_cfg_avmm_byte_en),
        .wdata       (i_cfg_avmm_wdata),
        .set_rw_both (in_ack && i_cfg_avmm_read && i_cfg_avmm_write),
        .set_oor     (in_ack && !in_range),
        .rd_off      (word_off[2:0]),
        .rd_data     (rf_rdata),
        .csr_reg     (o_csr_reg)
    );

    always_ff @(posedge i_cfg_avmm_clk or posedge i_cfg_avmm_rst) begin
        if (i_cfg_avmm_rst) begin
            state               <= IDLE;
            o_cfg_avmm_waitreq  <= 1'b1;
            o_cfg_avmm_rdatavld <= 1'b0;
            o_cfg_avmm_rdata    <= '0;
`ifdef AIB_CFG_AVMM_RDPIPE_EN
            rd_pipe             <= '0;
`endif
        end else begin
            o_cfg_avmm_waitreq  <= 1'b1;
            o_cfg_avmm_rdatavld <= 1'b0;
            o_cfg_avmm_rdata    <= '0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        state              <= ACK;
                        o_cfg_avmm_waitreq <= 1'b0;
                    end
                end
                ACK: begin
                    if (i_cfg_avmm_read && !i_cfg_avmm_write) begin
                        state <= RDV;
`ifdef AIB_CFG_AVMM_RDPIPE_EN
                        rd_pipe <= in_range ? rf_rdata : '0;
`else
                        o_cfg_avmm_rdatavld <= 1'b1;
                        o_cfg_avmm_rdata    <= in_range ? rf_rdata : '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RDV: begin
`ifdef AIB_CFG_AVMM_RDPIPE_EN
                    state               <= RDV2;
                    o_cfg_avmm_rdatavld <= 1'b1;
                    o_cfg_avmm_rdata    <= rd_pipe;
`else
                    state <= IDLE;
`endif
                end
                RDV2:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aib_cfg_avmm_rsp.sv
// Bench for aib_cfg_avmm_rsp: directed vector table, multi-cycle corner sequences and random traffic.
module tb_aib_cfg_avmm_rsp;

    localparam logic [5:0] ID = 6'd5;
`ifdef AIB_CFG_AVMM_RDPIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int WIN = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   channel_id = ID;
    logic [16:0]  addr = '0;
    logic [3:0]   be = '0;
    logic         rd_req = 1'b0;
    logic         wr_req = 1'b0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         rdatavld;
    logic         waitreq;
    logic [191:0] csr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: R/W words 1..6 and the two status flags
    logic [31:0] m_rw [1:6];
    logic [1:0]  m_st;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [5:0]  chan;
        logic [8:0]  off;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    aib_cfg_avmm_rsp dut (
        .i_cfg_avmm_clk      (clk),
        .i_cfg_avmm_rst      (rst),
        .i_channel_id        (channel_id),
        .i_cfg_avmm_addr     (addr),
        .i_cfg_avmm_byte_en  (be),
        .i_cfg_avmm_read     (rd_req),
        .i_cfg_avmm_write    (wr_req),
        .i_cfg_avmm_wdata    (wdata),
        .o_cfg_avmm_rdata    (rdata),
        .o_cfg_avmm_rdatavld (rdatavld),
        .o_cfg_avmm_waitreq  (waitreq),
        .o_csr_reg           (csr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_csr();
        logic [191:0] exp_csr;
        exp_csr = {m_rw[6], m_rw[5], m_rw[4], m_rw[3], m_rw[2], m_rw[1]};
        vectors++;
        if (csr !== exp_csr) begin
            miscompares++;
            $display("FAIL o_csr_reg: got %h, expected %h", csr, exp_csr);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 6; i++) m_rw[i] = '0;
        m_st = '0;
    endtask

    task automatic model_step(input logic rd, input logic wr, input logic [5:0] chan,
                              input logic [8:0] off, input logic [31:0] wd, input logic [3:0] b,
                              output logic [31:0] rexp);
        rexp = '0;
        if ((rd || wr) && chan == ID) begin
            if (wr) begin
                if (off == 7 && b[0])
                    m_st = m_st & ~wd[1:0];
                else if (off >= 1 && off <= 6)
                    for (int k = 0; k < 4; k++)
                        if (b[k]) m_rw[off][8*k +: 8] = wd[8*k +: 8];
                if (rd) m_st[0] = 1'b1;
                if (off >= 8) m_st[1] = 1'b1;
            end else if (off >= 8) begin
                m_st[1] = 1'b1;
            end else if (off == 0) begin
                rexp = 32'h0A1B_0100 + 32'(ID);
            end else if (off == 7) begin
                rexp = {30'd0, m_st};
            end else begin
                rexp = m_rw[off];
            end
        end
    endtask

    task automatic xact(input logic rd, input logic wr, input logic [16:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output int wcyc, output int vcyc, output logic [31:0] rdat,
                        output int nvld, output int nwlow, output int zviol);
        wcyc = -1; vcyc = -1; rdat = '0; nvld = 0; nwlow = 0; zviol = 0;
        @(negedge clk);
        rd_req = rd; wr_req = wr; addr = a; wdata = wd; be = b;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (!waitreq) begin
                nwlow++;
                if (wcyc < 0) wcyc = c;
            end
            if (rdatavld) begin
                nvld++;
                if (vcyc < 0) begin vcyc = c; rdat = rdata; end
            end else if (rdata != '0) begin
                zviol++;
            end
            if (wcyc > 0 && c == wcyc + 1) begin rd_req = 1'b0; wr_req = 1'b0; end
        end
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic run_xact(input logic rd, input logic wr, input logic [5:0] chan, input logic [8:0] off,
                            input logic [1:0] lsb, input logic [31:0] wd, input logic [3:0] b,
                            input logic [31:0] exp_rdata);
        int          wcyc, vcyc, nvld, nwlow, zviol;
        logic [31:0] rdat;
        logic        hit, rd_only;
        hit     = (rd || wr) && chan == ID;
        rd_only = hit && rd && !wr;
        xact(rd, wr, {chan, off, lsb}, wd, b, wcyc, vcyc, rdat, nvld, nwlow, zviol);
        chk("waitreq_low_cycle", wcyc, hit ? 1 : -1);
        chk("waitreq_low_count", nwlow, hit ? 1 : 0);
        chk("rdatavld_cycle", vcyc, rd_only ? LAT : -1);
        chk("rdatavld_count", nvld, rd_only ? 1 : 0);
        if (rd_only) chk("rdata", rdat, exp_rdata);
        chk("rdata_zero_when_invalid", zviol, 0);
        chk_csr();
    endtask

    task automatic model_and_run(input logic rd, input logic wr, input logic [5:0] chan, input logic [8:0] off,
                                 input logic [1:0] lsb, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] rexp;
        model_step(rd, wr, chan, off, wd, b, rexp);
        run_xact(rd, wr, chan, off, lsb, wd, b, rexp);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [5:0] chan, input logic [8:0] off,
                                input logic [31:0] wd, input logic [3:0] b, input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.chan = chan; v.off = off; v.wdata = wd; v.be = b; v.exp_rdata = exp;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rexp;
        logic [31:0] got;
        logic        rd, wr;
        logic [5:0]  chan;
        logic [8:0]  off;
        int          op, nv, first, second, vc;

        tbl.push_back(mk(0, 1, ID,    9'd1,  32'hA5A5_1234, 4'hF, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd1,  32'h0,         4'h0, 32'hA5A5_1234));
        tbl.push_back(mk(0, 1, ID,    9'd2,  32'hFFFF_FFFF, 4'hF, 32'h0));
        tbl.push_back(mk(0, 1, ID,    9'd2,  32'h0000_0000, 4'h5, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd2,  32'h0,         4'h0, 32'hFF00_FF00));
        tbl.push_back(mk(1, 0, 6'd6,  9'd1,  32'h0,         4'h0, 32'h0));
        tbl.push_back(mk(1, 1, ID,    9'd3,  32'hC0DE_3333, 4'hF, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd3,  32'h0,         4'h0, 32'hC0DE_3333));
        tbl.push_back(mk(1, 0, ID,    9'd7,  32'h0,         4'h0, 32'h1));
        tbl.push_back(mk(0, 1, ID,    9'd7,  32'h1,         4'hF, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd7,  32'h0,         4'h0, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'h20, 32'h0,         4'h0, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd7,  32'h0,         4'h0, 32'h2));
        tbl.push_back(mk(1, 0, ID,    9'd0,  32'h0,         4'h0, 32'h0A1B_0105));
        tbl.push_back(mk(1, 1, ID,    9'd7,  32'h3,         4'hF, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd7,  32'h0,         4'h0, 32'h1));
        tbl.push_back(mk(0, 1, ID,    9'd7,  32'h3,         4'h0, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd7,  32'h0,         4'h0, 32'h1));
        tbl.push_back(mk(0, 1, ID,    9'd1,  32'h0,         4'h0, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd1,  32'h0,         4'h0, 32'hA5A5_1234));
        tbl.push_back(mk(0, 1, 6'd6,  9'd1,  32'h0,         4'hF, 32'h0));
        tbl.push_back(mk(1, 0, ID,    9'd1,  32'h0,         4'h0, 32'hA5A5_1234));

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_waitreq", 32'(waitreq), 32'h1);
        chk("reset_rdatavld", 32'(rdatavld), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk_csr();
        rst = 1'b0;

        foreach (tbl[i]) begin
            model_step(tbl[i].rd, tbl[i].wr, tbl[i].chan, tbl[i].off, tbl[i].wdata, tbl[i].be, rexp);
            run_xact(tbl[i].rd, tbl[i].wr, tbl[i].chan, tbl[i].off, 2'b00,
                     tbl[i].wdata, tbl[i].be, tbl[i].exp_rdata);
        end

        // Reset landing in the ACK cycle of a write to offset 4
        @(negedge clk);
        wr_req = 1'b1; addr = {ID, 9'd4, 2'b00}; wdata = 32'hDEAD_BEEF; be = 4'hF;
        @(negedge clk);
        chk("wr4_ack_waitreq", 32'(waitreq), 32'h0);
        rst = 1'b1;
        #1;
        chk("wr4_rst_waitreq", 32'(waitreq), 32'h1);
        @(negedge clk);
        chk("wr4_rst_hold_waitreq", 32'(waitreq), 32'h1);
        chk("wr4_rst_rdatavld", 32'(rdatavld), 32'h0);
        wr_req = 1'b0; rst = 1'b0;
        model_reset();
        chk_csr();
        model_step(1, 0, ID, 9'd4, 32'h0, 4'h0, rexp);
        run_xact(1, 0, ID, 9'd4, 2'b00, 32'h0, 4'h0, 32'h0);
        model_step(1, 0, ID, 9'd0, 32'h0, 4'h0, rexp);
        run_xact(1, 0, ID, 9'd0, 2'b00, 32'h0, 4'h0, 32'h0A1B_0105);

        // Reset landing in the ACK cycle of a read: no data pulse may follow
        @(negedge clk);
        rd_req = 1'b1; addr = {ID, 9'd0, 2'b00};
        @(negedge clk);
        chk("rdabort_ack_waitreq", 32'(waitreq), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rd_req = 1'b0; rst = 1'b0;
        model_reset();
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdatavld) nv++;
        end
        chk("rdabort_rdatavld", nv, 0);

        // A write presented while the read is still in flight waits for IDLE
        model_and_run(0, 1, ID, 9'd1, 2'b00, 32'h1111_2222, 4'hF);
        @(negedge clk);
        rd_req = 1'b1; addr = {ID, 9'd1, 2'b00};
        first = -1; second = -1; vc = -1; got = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!waitreq) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (rdatavld && vc < 0) begin vc = c; got = rdata; end
            if (c == 2) begin
                rd_req = 1'b0; wr_req = 1'b1; addr = {ID, 9'd2, 2'b00};
                wdata = 32'h3C3C_5A5A; be = 4'hF;
            end
            if (second > 0 && c == second + 1) wr_req = 1'b0;
        end
        wr_req = 1'b0;
        chk("pend_first_waitreq", first, 1);
        chk("pend_read_vld_cycle", vc, LAT);
        chk("pend_read_data", got, 32'h1111_2222);
        chk("pend_second_waitreq", second, LAT + 2);
        model_step(0, 1, ID, 9'd2, 32'h3C3C_5A5A, 4'hF, rexp);
        chk_csr();

        // Random traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            op   = int'($urandom_range(0, 9));
            rd   = (op < 5) || (op == 9);
            wr   = (op >= 5);
            chan = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ID;
            off  = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
            model_and_run(rd, wr, chan, off, 2'($urandom), $urandom, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
